// File: rtl/dev_reshuffle_pkg.sv
// Shared definitions for the tile reshuffler / unshuffler pair:
// FSM state encoding and flat element indexing of a square tile.
package dev_reshuffle_pkg;

  // Unshuffler control states.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Flat index of element (r,c) in a row-major tile of dimension sp.
  function automatic int unsigned elem_idx(
    input int unsigned r,
    input int unsigned c,
    input int unsigned sp
  );
    return r * sp + c;
  endfunction

endpackage

// File: rtl/dev_unshuffler_colsel.sv
// Column selector: picks column beat_cnt of the held tile and lays its
// elements out as one narrow beat. Output is forced to zero when en is low
// so the beat bus is quiet whenever nothing is being offered.
module dev_unshuffler_colsel
  import dev_reshuffle_pkg::*;
#(
  parameter int SpatPar   = 8,
  parameter int DataWidth = 64
) (
  input  logic [SpatPar*DataWidth-1:0]     tile,
  input  logic [$clog2(SpatPar)-1:0]       beat_cnt,
  input  logic                             en,
  output logic [DataWidth-1:0]             z
);

  localparam int Elems = DataWidth / SpatPar;
  localparam int CntW  = $clog2(SpatPar);

  logic [31:0] col;

  assign col = {{(32 - CntW){1'b0}}, beat_cnt};

  // Element c of the beat is tile element (row c, column beat_cnt).
  always_comb begin
    z = '0;
    if (en) begin
      for (int unsigned c = 0; c < SpatPar; c++) begin
        z[c*Elems +: Elems] = tile[elem_idx(c, col, SpatPar)*Elems +: Elems];
      end
    end
  end

endmodule

// File: rtl/dev_unshuffler.sv
// Tile unshuffler: accepts one transposed tile per wide handshake, holds it,
// and emits its columns as SpatPar narrow beats (beat k = column k), which
// undoes the transpose applied upstream.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A source never drops valid or changes data
// while valid is high and ready is low. Here z_valid_o only drops after the
// last beat's handshake, and a_ready_o depends on z_ready_i and local state
// only, never on a_valid_i.
module dev_unshuffler
  import dev_reshuffle_pkg::*;
#(
  parameter int SpatPar   = 8,
  parameter int DataWidth = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [SpatPar*DataWidth-1:0] a_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  output logic [DataWidth-1:0]         z_o,
  output logic                         z_valid_o,
  input  logic                         z_ready_i,
  output logic                         busy_o
);

  localparam int                CntW     = $clog2(SpatPar);
  localparam logic [CntW-1:0]   LastBeat = CntW'(SpatPar - 1);

  state_e                       state_q, state_d;
  logic [CntW-1:0]              beat_q, beat_d;
  logic [SpatPar*DataWidth-1:0] tile_q, tile_d;
  logic                         last_beat;

  assign last_beat = (beat_q == LastBeat);

  // Next-state, counter, tile load and handshake outputs.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tile_d    = tile_q;
    a_ready_o = 1'b0;
    z_valid_o = 1'b0;
    busy_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        a_ready_o = 1'b1;
        if (a_valid_i) begin
          tile_d  = a_i;
          beat_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        z_valid_o = 1'b1;
        busy_o    = 1'b1;
        // Accept the next tile only as the last beat leaves, so there is
        // never a bubble between tiles and never an overwrite mid-tile.
        a_ready_o = last_beat && z_ready_i;
        if (z_ready_i) begin
          if (!last_beat) begin
            beat_d = beat_q + 1'b1;
          end else if (a_valid_i) begin
            tile_d = a_i;
            beat_d = '0;
          end else begin
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State, beat counter and tile register; synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tile_q  <= tile_d;
    end
  end

  dev_unshuffler_colsel #(
    .SpatPar   (SpatPar),
    .DataWidth (DataWidth)
  ) u_colsel (
    .tile     (tile_q),
    .beat_cnt (beat_q),
    .en       (z_valid_o),
    .z        (z_o)
  );

endmodule

// File: tb/tb_dev_unshuffler.sv
// Bench for dev_unshuffler at SpatPar=4, DataWidth=32.
module tb_dev_unshuffler;

  localparam int SP = 4;
  localparam int DW = 32;
  localparam int EW = DW / SP;

  logic               clk;
  logic               rst_n;
  logic [SP*DW-1:0]   a;
  logic               a_valid;
  logic               a_ready;
  logic [DW-1:0]      z;
  logic               z_valid;
  logic               z_ready;
  logic               busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] lit[4];
  logic [SP*DW-1:0] tile0, tile1;

  dev_unshuffler #(.SpatPar(SP), .DataWidth(DW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .a_i       (a),
    .a_valid_i (a_valid),
    .a_ready_o (a_ready),
    .z_o       (z),
    .z_valid_o (z_valid),
    .z_ready_i (z_ready),
    .busy_o    (busy)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile with element (r,c) = r*16 + c + base.
  function automatic logic [SP*DW-1:0] make_tile(input int base);
    logic [SP*DW-1:0] t;
    t = '0;
    for (int r = 0; r < SP; r++)
      for (int c = 0; c < SP; c++)
        t[(r*SP+c)*EW +: EW] = 8'(r*16 + c + base);
    return t;
  endfunction

  // Reference: view the tile as a matrix; beat k is column k, row c in lane c.
  function automatic logic [DW-1:0] model_beat(input logic [SP*DW-1:0] t, input int k);
    logic [EW-1:0] m[SP][SP];
    logic [DW-1:0] b;
    for (int r = 0; r < SP; r++)
      for (int c = 0; c < SP; c++)
        m[r][c] = t[(r*SP+c)*EW +: EW];
    b = '0;
    for (int lane = 0; lane < SP; lane++)
      b[lane*EW +: EW] = m[lane][k];
    return b;
  endfunction

  // Driver: advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; z_ready = 1'b0; a = '0;
    step(); step();
    @(negedge clk);
    total++; if (z_valid !== 1'b0) begin bad++; $display("FAIL reset_zvalid got=%b exp=0", z_valid); end
    total++; if (z !== '0) begin bad++; $display("FAIL reset_z got=%h exp=0", z); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_aready got=%b exp=1", a_ready); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    a = tile0; a_valid = 1'b1; z_ready = 1'b1;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", a_ready); end
    step();
    a_valid = 1'b0;
    for (int k = 0; k < SP; k++) begin
      @(negedge clk);
      total++; if (z_valid !== 1'b1 || z !== lit[k]) begin
        bad++; $display("FAIL single_beat%0d got=%b/%h exp=1/%h", k, z_valid, z, lit[k]);
      end
      total++; if (a_ready !== (k == SP-1)) begin
        bad++; $display("FAIL single_aready%0d got=%b exp=%b", k, a_ready, (k == SP-1));
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy%0d got=%b exp=1", k, busy); end
      step();
    end
    @(negedge clk);
    total++; if (z_valid !== 1'b0 || z !== '0 || a_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_idle got=v%b z%h r%b b%b exp=v0 z0 r1 b0", z_valid, z, a_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    a = tile0; a_valid = 1'b1; z_ready = 1'b1;
    step();
    a_valid = 1'b0;
    step();                         // beat 0 leaves
    z_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (z_valid !== 1'b1 || z !== lit[1] || a_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=v%b z%h r%b exp=v1 z%h r0", i, z_valid, z, a_ready, lit[1]);
      end
      step();
    end
    z_ready = 1'b1;
    for (int k = 1; k < SP; k++) begin
      @(negedge clk);
      total++; if (z_valid !== 1'b1 || z !== lit[k]) begin
        bad++; $display("FAIL bp_beat%0d got=%b/%h exp=1/%h", k, z_valid, z, lit[k]);
      end
      step();
    end
    @(negedge clk);
    total++; if (z_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", z_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    a = tile0; a_valid = 1'b1; z_ready = 1'b1;
    step();
    a = tile1;
    for (int i = 0; i < 2*SP; i++) begin
      e = (i < SP) ? lit[i] : lit[i-SP] + 32'h40404040;
      @(negedge clk);
      total++; if (z_valid !== 1'b1 || z !== e) begin
        bad++; $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", i, z_valid, z, e);
      end
      total++; if (a_ready !== ((i % SP) == SP-1)) begin
        bad++; $display("FAIL b2b_aready%0d got=%b exp=%b", i, a_ready, ((i % SP) == SP-1));
      end
      step();
      if (i == SP-1) a_valid = 1'b0;
    end
    @(negedge clk);
    total++; if (z_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", z_valid); end
  endtask

  task automatic test_early_valid();
    a = tile0; a_valid = 1'b1; z_ready = 1'b1;
    step();
    a = tile1;
    for (int k = 0; k < SP; k++) begin
      @(negedge clk);
      total++; if (a_ready !== (k == SP-1) || z !== lit[k]) begin
        bad++; $display("FAIL early_beat%0d got=r%b z%h exp=r%b z%h", k, a_ready, z, (k == SP-1), lit[k]);
      end
      step();
    end
    a_valid = 1'b0;
    for (int k = 0; k < SP; k++) begin
      @(negedge clk);
      total++; if (z_valid !== 1'b1 || z !== model_beat(tile1, k)) begin
        bad++; $display("FAIL early_t1_beat%0d got=%b/%h exp=1/%h", k, z_valid, z, model_beat(tile1, k));
      end
      step();
    end
  endtask

  task automatic test_last_stall();
    a = tile0; a_valid = 1'b1; z_ready = 1'b1;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < SP-1; k++) step();
    a = tile1; a_valid = 1'b1; z_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (a_ready !== 1'b0 || z_valid !== 1'b1 || z !== lit[SP-1]) begin
        bad++; $display("FAIL stall_last%0d got=r%b v%b z%h exp=r0 v1 z%h", i, a_ready, z_valid, z, lit[SP-1]);
      end
      step();
    end
    z_ready = 1'b1;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", a_ready); end
    step();
    a_valid = 1'b0;
    for (int k = 0; k < SP; k++) begin
      @(negedge clk);
      total++; if (z_valid !== 1'b1 || z !== model_beat(tile1, k)) begin
        bad++; $display("FAIL stall_t1_beat%0d got=%b/%h exp=1/%h", k, z_valid, z, model_beat(tile1, k));
      end
      step();
    end
  endtask

  task automatic test_reset_mid_tile();
    a = tile0; a_valid = 1'b1; z_ready = 1'b1;
    step();
    a_valid = 1'b0;
    step(); step();                 // now on beat 2
    @(negedge clk);
    total++; if (z !== lit[2]) begin bad++; $display("FAIL rst_mid_pre got=%h exp=%h", z, lit[2]); end
    rst_n = 1'b0;
    step();
    @(negedge clk);
    total++; if (z_valid !== 1'b0 || busy !== 1'b0 || a_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid got=v%b b%b r%b exp=v0 b0 r1", z_valid, busy, a_ready);
    end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < SP; i++) begin
      @(negedge clk);
      total++; if (z_valid !== 1'b0 || z !== '0) begin
        bad++; $display("FAIL rst_stale%0d got=v%b z%h exp=v0 z0", i, z_valid, z);
      end
      step();
    end
  endtask

  // Random traffic against a queue-based reference: each accepted tile
  // contributes its columns to exp_q; ready is expected whenever the queue
  // is empty or its single remaining beat leaves this cycle.
  task automatic test_random();
    int drain;
    logic exp_rdy;
    exp_q.delete();
    a_valid = 1'b0; z_ready = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!a_valid && ($urandom_range(0, 2) != 0)) begin
        a = {$urandom, $urandom, $urandom, $urandom};
        a_valid = 1'b1;
      end
      z_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && z_ready);
      total++; if (a_ready !== exp_rdy) begin
        bad++; $display("FAIL rand_aready c%0d got=%b exp=%b", cyc, a_ready, exp_rdy);
      end
      total++; if (z_valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rand_zvalid c%0d got=%b exp=%b", cyc, z_valid, (exp_q.size() != 0));
      end
      if (z_valid && exp_q.size() != 0) begin
        total++; if (z !== exp_q[0]) begin
          bad++; $display("FAIL rand_beat c%0d got=%h exp=%h", cyc, z, exp_q[0]);
        end
      end else if (!z_valid) begin
        total++; if (z !== '0) begin bad++; $display("FAIL rand_zquiet c%0d got=%h exp=0", cyc, z); end
      end
      if (z_valid && z_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (a_valid && a_ready)
        for (int k = 0; k < SP; k++) exp_q.push_back(model_beat(a, k));
      step();
      if (a_valid && a_ready) a_valid = 1'b0;
    end
    a_valid = 1'b0; z_ready = 1'b1;
    drain = 0;
    while (exp_q.size() != 0 && drain < 4*SP) begin
      @(negedge clk);
      if (z_valid) begin
        total++; if (z !== exp_q[0]) begin bad++; $display("FAIL rand_drain got=%h exp=%h", z, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      step();
      drain++;
    end
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    lit[0] = 32'h30201000; lit[1] = 32'h31211101;
    lit[2] = 32'h32221202; lit[3] = 32'h33231303;
    tile0 = make_tile(0);
    tile1 = make_tile(8'h40);
    rst_n = 1'b0; a = '0; a_valid = 1'b0; z_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_early_valid();
    test_last_stall();
    test_reset_mid_tile();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
